// File: rtl/apb_timer_mc_if.sv
// APB slave bus bundle shared by apb_timer_mc and its bus master.
interface apb_timer_mc_if #(parameter int APB_ADDR_WIDTH = 12);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_timer_mc.sv
// N_CH independent prescaled compare timers behind one APB slave.
// Optional: define APB_TIMER_MC_SNAPSHOT_EN for coherent CNT_LO/CNT_HI reads via a shadow.
module apb_timer_mc_ch #(
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 12,
  parameter int STEP_W  = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        wr_en,
  input  logic [2:0]  off,
  input  logic [31:0] wdata,
  input  logic        st_clr,
`ifdef APB_TIMER_MC_SNAPSHOT_EN
  input  logic        snap,
`endif
  output logic [31:0] rdata,
  output logic        status,
  output logic        irq
);
  localparam int HI_W = CNT_W - 32;
  localparam logic [2:0] A_CTRL = 3'd0, A_CFG = 3'd1, A_CNT_LO = 3'd2, A_CNT_HI = 3'd3,
                         A_CMP_LO = 3'd4, A_CMP_HI = 3'd5, A_IRQ_EN = 3'd6;

  logic               en, periodic, irq_en, tick, match;
  logic [STEP_W-1:0]  step;
  logic [PRESC_W-1:0] presc, presc_cnt, presc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cmp;
  logic [HI_W-1:0]    cnt_hi_rd;

  assign tick  = en && (presc_cnt == presc);
  // >= rather than == so a step that jumps past cmp still matches
  assign match = en && (cnt >= cmp);
  assign irq   = status & irq_en;

  always_comb begin
    cnt_nxt = cnt;
    if (match) begin
      if (periodic) cnt_nxt = '0;
    end else if (tick) begin
      cnt_nxt = cnt + CNT_W'(step);
    end
    if (wr_en && off == A_CNT_LO) cnt_nxt[31:0]       = wdata;
    if (wr_en && off == A_CNT_HI) cnt_nxt[CNT_W-1:32] = wdata[HI_W-1:0];
  end

  always_comb begin
    presc_nxt = presc_cnt + PRESC_W'(1);
    if (!en || tick || (match && periodic) || (wr_en && off == A_CFG)) presc_nxt = '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en        <= 1'b0;
      periodic  <= 1'b0;
      irq_en    <= 1'b0;
      step      <= '0;
      presc     <= '0;
      presc_cnt <= '0;
      cnt       <= '0;
      cmp       <= '1;
      status    <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      presc_cnt <= presc_nxt;
      if (match)       status <= 1'b1;
      else if (st_clr) status <= 1'b0;
      if (match && !periodic) en <= 1'b0;
      // bus write placed last so it overrides the one-shot disable
      if (wr_en) begin
        case (off)
          A_CTRL:   {periodic, en} <= wdata[1:0];
          A_CFG: begin
            step  <= wdata[16 +: STEP_W];
            presc <= wdata[PRESC_W-1:0];
          end
          A_CMP_LO: cmp[31:0]       <= wdata;
          A_CMP_HI: cmp[CNT_W-1:32] <= wdata[HI_W-1:0];
          A_IRQ_EN: irq_en          <= wdata[0];
          default: ;
        endcase
      end
    end
  end

`ifdef APB_TIMER_MC_SNAPSHOT_EN
  logic [HI_W-1:0] shadow;
  always_ff @(posedge HCLK) begin
    if (HRESET)    shadow <= '0;
    else if (snap) shadow <= cnt[CNT_W-1:32];
  end
  assign cnt_hi_rd = shadow;
`else
  assign cnt_hi_rd = cnt[CNT_W-1:32];
`endif

  always_comb begin
    rdata = '0;
    case (off)
      A_CTRL:   rdata = {30'd0, periodic, en};
      A_CFG:    rdata = {16'(step), 16'(presc)};
      A_CNT_LO: rdata = cnt[31:0];
      A_CNT_HI: rdata = 32'(cnt_hi_rd);
      A_CMP_LO: rdata = cmp[31:0];
      A_CMP_HI: rdata = 32'(cmp[CNT_W-1:32]);
      A_IRQ_EN: rdata = {31'd0, irq_en};
      default: ;
    endcase
  end
endmodule

module apb_timer_mc #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_CH           = 4,
  parameter int CNT_W          = 64,
  parameter int PRESC_W        = 12,
  parameter int STEP_W         = 16
) (
  input  logic            HCLK,
  input  logic            HRESET,
  apb_timer_mc_if.slave   apb,
  output logic [N_CH-1:0] irq_o,
  output logic            irq_any_o
);
  localparam int AW = APB_ADDR_WIDTH;

  logic [2:0]             ch_idx, off;
  logic                   in_ch, in_st, acc, wr;
  logic [N_CH-1:0]        status;
  logic [N_CH-1:0][31:0]  ch_rdata;

  assign ch_idx = apb.PADDR[7:5];
  assign off    = apb.PADDR[4:2];
  // channel window is 0x000-0x0FF, word aligned, offsets 0x00-0x18 only
  assign in_ch  = (apb.PADDR[AW-1:8] == '0) && (apb.PADDR[1:0] == 2'b00) &&
                  (off != 3'd7) && ({1'b0, ch_idx} < 4'(N_CH));
  assign in_st  = (apb.PADDR == AW'('h800));
  assign acc    = apb.PSEL && apb.PENABLE;
  assign wr     = acc && apb.PWRITE;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic hit;
    assign hit = in_ch && (ch_idx == 3'(c));
    apb_timer_mc_ch #(.CNT_W(CNT_W), .PRESC_W(PRESC_W), .STEP_W(STEP_W)) u_ch (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .wr_en  (wr && hit),
      .off    (off),
      .wdata  (apb.PWDATA),
      .st_clr (wr && in_st && apb.PWDATA[c]),
`ifdef APB_TIMER_MC_SNAPSHOT_EN
      .snap   (acc && !apb.PWRITE && hit && (off == 3'd2)),
`endif
      .rdata  (ch_rdata[c]),
      .status (status[c]),
      .irq    (irq_o[c])
    );
  end

  assign irq_any_o   = |irq_o;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = acc && !(in_ch || in_st);

  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      if (in_st) apb.PRDATA = 32'(status);
      else if (in_ch) begin
        for (int c = 0; c < N_CH; c++)
          if (ch_idx == 3'(c)) apb.PRDATA = ch_rdata[c];
      end
    end
  end
endmodule

// File: doc/apb_timer_mc.md
Name: apb_timer_mc

Overview:
- Multi-channel successor to the single-channel APB timer: N_CH independent timers behind one APB slave.
- Each channel has a configurable-width counter, prescaler, step increment, compare value, one-shot/periodic mode and a sticky interrupt status.
- Sits on the peripheral APB bus beside the existing timer; per-channel and combined interrupt lines go to the PLIC.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width.
- N_CH, 4, number of channels (1..8).
- CNT_W, 64, counter/compare width (33..64); unused upper bits read 0.
- PRESC_W, 12, prescaler width.
- STEP_W, 16, step width.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous active-high reset.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  write data.
- PWRITE  in  1  write strobe.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  unmapped-address error.
- irq_o  out  N_CH  per-channel interrupt = status & irq_en.
- irq_any_o  out  1  OR of irq_o.

Behaviour:
- Address map: channel c at base c*0x20.
  - +0x00 CTRL: bit0 EN, bit1 PERIODIC.
  - +0x04 CFG: [31:16] step, [PRESC_W-1:0] prescale.
  - +0x08 CNT_LO.
  - +0x0C CNT_HI.
  - +0x10 CMP_LO.
  - +0x14 CMP_HI.
  - +0x18 IRQ_EN: bit0.
  - Global 0x800 STATUS: [N_CH-1:0], write-1-to-clear.
- Reset: all registers and counters 0; CMP = all ones; outputs PRDATA=0, PSLVERR=0, irq_o=0, irq_any_o=0.
- Write: PSEL&PENABLE&PWRITE commits on that HCLK edge.
- Read: PRDATA is combinational from PADDR while PSEL&!PWRITE, else 0.
- PSLVERR: combinational, high while PSEL&PENABLE for an address outside the map or a channel index >= N_CH. Such writes are dropped; reads return 0.
- Per-channel prescaler presc_cnt (PRESC_W bits), active while EN=1:
  - If presc_cnt==prescale: presc_cnt<=0 and tick=1; else presc_cnt++.
  - presc_cnt is cleared whenever EN=0 or on a CFG write.
- Counter: on tick, cnt <= cnt + step, modulo 2^CNT_W; wrap is silent.
- Match: match = EN & (cnt >= cmp), evaluated on the registered cnt. The ≥ comparison covers step overshoot. On a match edge:
  - STATUS[c] <= 1.
  - If PERIODIC: cnt <= 0 and presc_cnt <= 0; the increment is suppressed that edge.
  - If one-shot: EN <= 0 and cnt holds its value.
- Latency:
  - First increment on the (prescale+1)-th edge after the EN write.
  - irq_o rises one edge after cnt first satisfies cnt >= cmp.
  - Periodic interval = (ceil(cmp/step)*(prescale+1) + 1) cycles.
- Simultaneous events:
  - APB write to CNT or CTRL in the same cycle as a tick or match: the APB write wins for that register. STATUS is still set if the match occurred.
  - W1C and a new match on the same edge: set wins.
- cmp=0 with EN=1: match every cycle.
  - Periodic: STATUS stays set (W1C cannot clear it).
  - One-shot: a single match, then EN clears.
- Reset mid-count: everything returns to reset values on the next edge; irq_o drops that edge.
- Writing EN=0: counting freezes; cnt and STATUS are retained.

Optional Feature:
- Macro: APB_TIMER_MC_SNAPSHOT_EN.
- Defined:
  - A read of CNT_LO latches the channel's cnt[CNT_W-1:32] into a per-channel shadow register on that edge.
  - CNT_HI then returns the shadow, giving a coherent 64-bit read.
  - The shadow resets to 0.
- Undefined: CNT_HI returns the live upper bits; no shadow registers are built.

Test Plan:
- Channel 0, prescale=0, step=1, CMP=10, IRQ_EN=1, write CTRL=1 -> irq_o[0] rises exactly 11 edges after the CTRL write; CTRL reads 0 (one-shot); CNT_LO reads 10.
- Channel 1, prescale=3, step=4, CMP=17, CTRL=3 (periodic) -> first irq after 20+1 cycles; after W1C STATUS=0x2, irq_o[1] re-asserts every 21 cycles; CNT wraps to 0 each time.
- Channels 0 and 2 run concurrently with different CMP values (5 and 9), prescale=0, step=1 -> irq_o=0x1 then 0x5; irq_any_o follows the OR; W1C 0x1 clears only bit0.
- W1C of STATUS issued on the same edge as a periodic match -> STATUS bit stays 1.
- Access to 0x0F0 with N_CH=4 (channel 7), and to 0x81C -> PSLVERR=1, PRDATA=0, no register changes.
- With APB_TIMER_MC_SNAPSHOT_EN: CNT=0x0000_0001_FFFF_FFFF, step=1, read CNT_LO then, three cycles later, read CNT_HI -> CNT_HI=1 (live value would be 2 after the wrap); without the macro -> 2.
